// File: rtl/alu_md_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package alu_md_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'b000,
        MD_MULT  = 3'b001,
        MD_MULTU = 3'b010,
        MD_DIV   = 3'b011,
        MD_DIVU  = 3'b100,
        MD_MTHI  = 3'b101,
        MD_MTLO  = 3'b110
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CALC = 1'b1
    } state_e;

endpackage

// File: rtl/alu_md_if.sv
// Request/response bundle between the EX stage and the multiply/divide unit.
interface alu_md_if #(
    parameter int unsigned WIDTH = 32
);
    logic             flush;
    logic             start;
    logic [2:0]       md_op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output flush, start, md_op, a, b,
        input  busy, done, hi, lo
    );

    modport slave (
        input  flush, start, md_op, a, b,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/alu_md_sign_fix.sv
// Final-write sign correction: 2*WIDTH product negation, or independent
// quotient/remainder negation for divides.
module md_sign_fix #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               is_div,
    input  logic               neg_prod,
    input  logic               neg_quo,
    input  logic               neg_rem,
    input  logic [2*WIDTH-1:0] raw,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo
);
    logic [2*WIDTH-1:0] prod_neg;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;

    // Select corrected HI/LO from the raw magnitude result.
    always_comb begin
        prod_neg = -raw;
        quo      = raw[WIDTH-1:0];
        rem      = raw[2*WIDTH-1:WIDTH];
        hi       = raw[2*WIDTH-1:WIDTH];
        lo       = raw[WIDTH-1:0];
        if (is_div) begin
            lo = neg_quo ? -quo : quo;
            hi = neg_rem ? -rem : rem;
        end else if (neg_prod) begin
            hi = prod_neg[2*WIDTH-1:WIDTH];
            lo = prod_neg[WIDTH-1:0];
        end
    end
endmodule

// File: rtl/alu_md.sv
// Iterative multiply/divide unit with HI/LO registers: one shift-add or
// restoring-subtract step per cycle, WIDTH cycles per operation.
module alu_md
    import alu_md_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst,
    alu_md_if.slave  bus
);
    localparam int unsigned   CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    // mult: {accumulator, multiplier}; div: {remainder, dividend/quotient}
    logic [2*WIDTH-1:0] work_q, work_d;
    // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               bzero_q, bzero_d;

    logic               op_signed;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     trial;
    logic [WIDTH-1:0]   sub_res;
    logic [2*WIDTH-1:0] step;
    logic [WIDTH-1:0]   fix_hi, fix_lo;

    // Operand conditioning for the accept edge: sign flags and magnitudes.
    always_comb begin
        op_signed = (bus.md_op == MD_MULT) || (bus.md_op == MD_DIV);
        a_neg     = op_signed & bus.a[WIDTH-1];
        b_neg     = op_signed & bus.b[WIDTH-1];
        a_mag     = a_neg ? -bus.a : bus.a;
        b_mag     = b_neg ? -bus.b : bus.b;
    end

    // One iteration step of the shift-add multiplier or restoring divider.
    always_comb begin
        addend  = work_q[0] ? opnd_q : {WIDTH{1'b0}};
        add_sum = {1'b0, work_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
        trial   = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
        sub_res = trial[WIDTH-1:0] - opnd_q;
        if (is_div_q) begin
            if (trial >= {1'b0, opnd_q}) begin
                step = {sub_res, work_q[WIDTH-2:0], 1'b1};
            end else begin
                step = {trial[WIDTH-1:0], work_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            step = {add_sum, work_q[WIDTH-1:1]};
        end
    end

    // Divide by zero yields remainder |a| and an all-ones quotient; the
    // remainder still takes the dividend sign (giving back a), while the
    // quotient correction is suppressed.
    md_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
        .is_div   (is_div_q),
        .neg_prod (neg_res_q),
        .neg_quo  (neg_res_q & ~bzero_q),
        .neg_rem  (neg_rem_q),
        .raw      (step),
        .hi       (fix_hi),
        .lo       (fix_lo)
    );

    // Control FSM: accept requests in IDLE, iterate in CALC, flush aborts.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        hi_d      = hi_q;
        lo_d      = lo_q;
        work_d    = work_q;
        opnd_d    = opnd_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        bzero_d   = bzero_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start && !bus.flush) begin
                    case (bus.md_op)
                        MD_MTHI: hi_d = bus.a;
                        MD_MTLO: lo_d = bus.a;
                        MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                            is_div_d  = (bus.md_op == MD_DIV) || (bus.md_op == MD_DIVU);
                            neg_res_d = a_neg ^ b_neg;
                            neg_rem_d = a_neg;
                            bzero_d   = (bus.b == '0);
                            if (is_div_d) begin
                                work_d = {{WIDTH{1'b0}}, a_mag};
                                opnd_d = b_mag;
                            end else begin
                                work_d = {{WIDTH{1'b0}}, b_mag};
                                opnd_d = a_mag;
                            end
                            cnt_d   = '0;
                            busy_d  = 1'b1;
                            state_d = ST_CALC;
                        end
                        default: ;
                    endcase
                end
            end
            ST_CALC: begin
                if (bus.flush) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    work_d = step;
                    cnt_d  = cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        hi_d    = fix_hi;
                        lo_d    = fix_lo;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            work_q    <= '0;
            opnd_q    <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            bzero_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            work_q    <= work_d;
            opnd_q    <= opnd_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            bzero_q   <= bzero_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_alu_md.sv
// Directed bench for alu_md at WIDTH=32: vector table plus hand sequences.
module tb_alu_md;
    import alu_md_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    alu_md_if #(.WIDTH(32)) bus ();

    alu_md #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv);
        bus.start = 1'b1;
        bus.md_op = op;
        bus.a     = av;
        bus.b     = bv;
        tick();
        bus.start = 1'b0;
        bus.md_op = MD_NONE;
        bus.a     = $urandom;
        bus.b     = $urandom;
    endtask

    // Issue, then wait (bounded) for done; lat = edges from accept to done.
    task automatic run_op(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv,
                          output int lat, output int bcy);
        issue(op, av, bv);
        lat = 0;
        bcy = bus.busy ? 1 : 0;
        while (!bus.done && lat < 100) begin
            tick();
            lat++;
            if (bus.busy) bcy++;
        end
    endtask

    initial begin
        int lat, bcy, dones;

        vecs[0]  = '{MD_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[1]  = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[2]  = '{MD_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[4]  = '{MD_DIVU,  32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF};
        vecs[5]  = '{MD_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
        vecs[6]  = '{MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[7]  = '{MD_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[8]  = '{MD_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
        vecs[9]  = '{MD_DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};
        vecs[10] = '{MD_MULT,  32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFB};

        bus.flush = 1'b0;
        bus.start = 1'b0;
        bus.md_op = MD_NONE;
        bus.a     = '0;
        bus.b     = '0;
        rst       = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_busy", {31'd0, bus.busy}, 32'd0);
        chk("reset_done", {31'd0, bus.done}, 32'd0);
        chk("reset_hi", bus.hi, 32'd0);
        chk("reset_lo", bus.lo, 32'd0);

        // mthi / mtlo: write next edge, no done
        issue(MD_MTHI, 32'h00001234, 32'h0);
        chk("mthi_hi", bus.hi, 32'h00001234);
        chk("mthi_done", {31'd0, bus.done}, 32'd0);
        chk("mthi_busy", {31'd0, bus.busy}, 32'd0);
        issue(MD_MTLO, 32'h00005678, 32'h0);
        chk("mtlo_lo", bus.lo, 32'h00005678);
        chk("mtlo_done", {31'd0, bus.done}, 32'd0);

        // flush in IDLE suppresses mthi
        bus.flush = 1'b1;
        issue(MD_MTHI, 32'h0000DEAD, 32'h0);
        bus.flush = 1'b0;
        chk("idle_flush_hi", bus.hi, 32'h00001234);
        chk("idle_flush_busy", {31'd0, bus.busy}, 32'd0);

        // flush at cycle 10 of a multiply
        issue(MD_MULT, 32'h00000003, 32'h00000005);
        for (int i = 0; i < 9; i++) tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("flush10_busy", {31'd0, bus.busy}, 32'd0);
        dones = bus.done ? 1 : 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.done) dones++;
        end
        chk("flush10_nodone", dones, 32'd0);
        chk("flush10_hi", bus.hi, 32'h00001234);
        chk("flush10_lo", bus.lo, 32'h00005678);

        // flush on the final-iteration edge
        issue(MD_MULTU, 32'h00000003, 32'h00000005);
        for (int i = 0; i < 31; i++) tick();
        chk("final_busy_pre", {31'd0, bus.busy}, 32'd1);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("final_flush_done", {31'd0, bus.done}, 32'd0);
        chk("final_flush_busy", {31'd0, bus.busy}, 32'd0);
        chk("final_flush_hi", bus.hi, 32'h00001234);
        chk("final_flush_lo", bus.lo, 32'h00005678);

        // vector table
        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bcy);
            chk($sformatf("vec%0d_latency", i), lat, 32'd32);
            chk($sformatf("vec%0d_busy_cycles", i), bcy, 32'd32);
            chk($sformatf("vec%0d_hi", i), bus.hi, vecs[i].exp_hi);
            chk($sformatf("vec%0d_lo", i), bus.lo, vecs[i].exp_lo);
            tick();
            chk($sformatf("vec%0d_done_pulse", i), {31'd0, bus.done}, 32'd0);
        end

        // back-to-back: divu issued in the done cycle of a div
        run_op(MD_DIV, 32'hFFFFFFF9, 32'h00000002, lat, bcy);
        chk("b2b_first_lo", bus.lo, 32'hFFFFFFFD);
        chk("b2b_first_hi", bus.hi, 32'hFFFFFFFF);
        chk("b2b_first_done", {31'd0, bus.done}, 32'd1);
        run_op(MD_DIVU, 32'h00000007, 32'h00000002, lat, bcy);
        chk("b2b_latency", lat, 32'd32);
        chk("b2b_lo", bus.lo, 32'h00000003);
        chk("b2b_hi", bus.hi, 32'h00000001);

        // start while busy is ignored
        issue(MD_MULTU, 32'h00000003, 32'h00000004);
        lat = 0;
        while (!bus.done && lat < 100) begin
            if (lat == 5) begin
                bus.start = 1'b1;
                bus.md_op = MD_DIVU;
                bus.a     = 32'h00000064;
                bus.b     = 32'h00000007;
            end
            tick();
            bus.start = 1'b0;
            bus.md_op = MD_NONE;
            lat++;
        end
        chk("midstart_latency", lat, 32'd32);
        chk("midstart_lo", bus.lo, 32'h0000000C);
        chk("midstart_hi", bus.hi, 32'h00000000);
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.done || bus.busy) dones++;
        end
        chk("midstart_no_second_op", dones, 32'd0);

        // reset mid-divide
        issue(MD_DIV, 32'h00000064, 32'h00000007);
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_hi", bus.hi, 32'd0);
        chk("rst_mid_lo", bus.lo, 32'd0);
        chk("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_mid_done", {31'd0, bus.done}, 32'd0);
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.done) dones++;
        end
        chk("rst_mid_nodone", dones, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_md.md
Name: alu_md

Overview:
- Parametrised iterative multiply/divide unit with architectural HI/LO registers.
- Companion to the combinational ALU in the EX stage of the MIPS core; implements mult, multu, div, divu, mthi and mtlo.
- Uses a start/busy/done handshake; the pipeline stalls on busy.
- Flushable by an exception, with no architectural side effects.

Parameters:
- WIDTH, 32: operand, HI and LO width (must be at least 4).
- CW, $clog2(WIDTH+1): iteration counter width (derived; not overridden).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  abort the operation in flight or presented this cycle; HI/LO unchanged.
- start  in  1  operation request; sampled only when busy=0.
- md_op  in  3  000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo, 111 reserved (treated as none).
- a  in  WIDTH  multiplicand, dividend, or mthi/mtlo source.
- b  in  WIDTH  multiplier or divisor.
- busy  out  1  iterative operation in progress (registered).
- done  out  1  one-cycle pulse; HI/LO updated on the same edge.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset: state IDLE; busy=0, done=0, hi=0, lo=0, counter=0. Reset overrides every other input, including mid-operation.
- States:
  - IDLE: accepts requests.
  - CALC: one shift-add or restoring-subtract step per cycle.
- Accept (IDLE, start=1, flush=0):
  - mthi: hi<=a next edge; done stays 0; stays IDLE.
  - mtlo: lo<=a next edge; done stays 0; stays IDLE.
  - mult/multu/div/divu: latch |a|, |b| (signed ops) or raw a, b (unsigned ops); latch sign flags and op; busy<=1; counter<=0; state CALC.
  - none/reserved: no effect.
- CALC: counter increments every cycle.
  - When counter reaches WIDTH-1, that edge writes the final, sign-corrected result to hi/lo, sets done<=1 and busy<=0, and returns to IDLE.
  - Latency: start edge E0, result edge E(WIDTH); busy is high for exactly WIDTH cycles.
- Multiply:
  - Unsigned 2*WIDTH product; hi = upper half, lo = lower half.
  - Signed: product of magnitudes, two's-complement negated over 2*WIDTH bits if the operand signs differ.
- Divide (restoring, unsigned on magnitudes):
  - lo = quotient, hi = remainder.
  - Signed: quotient negated if the signs differ; remainder takes the sign of the dividend.
  - Signed MIN/-1: lo=MIN, hi=0 (falls out of magnitude arithmetic; no trap).
  - b=0, any signedness: hi=a, lo=all ones; no sign fix-up, still WIDTH cycles.
- Magnitude of MIN is 2^(WIDTH-1), held unsigned in a WIDTH-bit register; this is correct.
- start while busy=1: ignored; inputs are not re-sampled.
- flush:
  - In CALC, state<=IDLE and busy<=0 next edge; no done; hi/lo untouched.
  - On the final-iteration edge, flush wins: no write and no done.
  - In IDLE, suppresses any start presented that cycle, including mthi/mtlo.
- done is exactly one cycle; it never asserts for mthi, mtlo, a flush or a reset.
- A new start is accepted in the same cycle done=1, since busy=0; back-to-back issue is allowed.
- a and b are don't-care except on the accept edge.

Decomposition:
- Package alu_md_pkg:
  - md_op encodings (MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO).
  - State enum (ST_IDLE, ST_CALC).
- Sub-module md_sign_fix (combinational): 2*WIDTH negation and quotient/remainder sign selection for the final write. Keeps the control FSM and iteration datapath in alu_md.

Test Plan (WIDTH=32):
- mult a=0xFFFFFFFD (-3), b=7 -> done one cycle at E32, hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high for 32 cycles.
- multu a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- div a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; then divu a=7, b=2 issued in the done cycle -> lo=3, hi=1 at E32 of the second op.
- div 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0; divu 5/0 -> hi=5, lo=0xFFFFFFFF.
- mult in flight, flush at cycle 10 -> busy=0 next cycle, no done, hi/lo keep prior values. Also: start asserted mid-operation ignored; flush on the final iteration leaves hi/lo unchanged.
- mthi a=0x1234 while idle -> hi=0x1234 next edge, done=0. Also: rst asserted mid-div -> hi=lo=0, busy=0, done=0 next edge.
